// File: rtl/keyboard_ctrl.sv
// Keypad latch sequencer: captures latched keys, pulses key_clear, encodes codes into a FIFO.
// Optional KBD_CTRL_RR_EN selects round-robin drain order (default: lowest index first).
`timescale 1ns/1ps
module keyboard_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int CLR_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] key_reg,
  output logic        key_clear,
  input  logic        rd_en,
  output logic [3:0]  rd_data,
  output logic        rd_valid,
  output logic        irq,
  output logic [4:0]  fifo_cnt,
  output logic        ovf,
  input  logic        ovf_clr,
  output logic [2:0]  state_dbg
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [4:0]  DEPTH5   = 5'(FIFO_DEPTH);
  localparam logic [15:0] CLR_LAST = 16'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CAPTURE, CLEAR, SETTLE, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [15:0]     sync1_q, key_sync_q;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     pending_q, pending_d;
  logic            key_clear_q;
  logic            push_req, push_ok, pop, full, empty;
  logic            grant_vld;
  logic [3:0]      grant_idx, idx;
  logic [3:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [4:0]      fifo_cnt_q;
  logic            ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      key_sync_q <= '0;
    end else begin
      sync1_q    <= key_reg;
      key_sync_q <= sync1_q;
    end
  end

`ifdef KBD_CTRL_RR_EN
  logic [3:0] rr_q;

  // Search starts one past the last grant; descending loop leaves the nearest hit.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 4'd0;
    idx       = 4'd0;
    for (int i = 16; i >= 1; i--) begin
      idx = rr_q + 4'(i);
      if (pending_q[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           rr_q <= 4'd15;
    else if (push_req) rr_q <= grant_idx;
  end
`else
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 4'd0;
    idx       = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      idx = 4'(i);
      if (pending_q[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    push_req  = 1'b0;
    case (state_q)
      IDLE: if (|key_sync_q) state_d = CAPTURE;
      CAPTURE: begin
        pending_d = pending_q | key_sync_q;
        cnt_d     = '0;
        state_d   = CLEAR;
      end
      CLEAR: begin
        pending_d = pending_q | key_sync_q;
        if (cnt_q == CLR_LAST) begin
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      // Two quiet cycles let the cleared latch flush through the synchronizer.
      SETTLE: begin
        if (cnt_q == 16'd1) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DRAIN: begin
        if (!grant_vld) begin
          state_d = IDLE;
        end else begin
          push_req             = 1'b1;
          pending_d[grant_idx] = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pending_q   <= '0;
      key_clear_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      key_clear_q <= (state_d == CLEAR);
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign empty   = (fifo_cnt_q == 5'd0);
  assign full    = (fifo_cnt_q == DEPTH5);
  assign pop     = rd_en && !empty;
  assign push_ok = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= grant_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop)      fifo_cnt_q <= fifo_cnt_q + 5'd1;
      else if (!push_ok && pop) fifo_cnt_q <= fifo_cnt_q - 5'd1;
      if (ovf_clr)                  ovf_q <= 1'b0;
      else if (push_req && !push_ok) ovf_q <= 1'b1;
    end
  end

  assign key_clear = key_clear_q;
  assign rd_valid  = !empty;
  assign irq       = !empty;
  assign rd_data   = empty ? 4'd0 : mem_q[rd_ptr_q];
  assign fifo_cnt  = fifo_cnt_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_keyboard_ctrl.sv
// Bench for keyboard_ctrl: latch model, scoreboard of expected key codes, timing and boundary checks.
`timescale 1ns/1ps
module tb_keyboard_ctrl;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] key_reg;
  logic        key_clear;
  logic        rd_en;
  logic [3:0]  rd_data;
  logic        rd_valid;
  logic        irq;
  logic [4:0]  fifo_cnt;
  logic        ovf;
  logic        ovf_clr;
  logic [2:0]  state_dbg;

  logic [3:0]  exp_q[$];
  logic [3:0]  rr_model;
  int          n_checks = 0;
  int          n_errors = 0;

  keyboard_ctrl #(.FIFO_DEPTH(DEPTH), .CLR_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .key_reg(key_reg), .key_clear(key_clear),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .irq(irq),
    .fifo_cnt(fifo_cnt), .ovf(ovf), .ovf_clr(ovf_clr), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Latch model: a completed clear pulse wipes the latch; a reset-truncated one does not.
  always @(negedge key_clear) if (!rst) key_reg = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic press_mask(input logic [15:0] m);
    if (!key_clear) key_reg = key_reg | m;
  endtask

  // Expected drain order for one round; codes beyond cap are dropped.
  task automatic push_round(input logic [15:0] keys, input int cap);
    logic [3:0] start;
    logic [3:0] id;
    start = rr_model;
    for (int i = 0; i < 16; i++) begin
`ifdef KBD_CTRL_RR_EN
      id = start + 4'(i) + 4'd1;
`else
      id = 4'(i);
`endif
      if (keys[id]) begin
        if (exp_q.size() < cap) exp_q.push_back(id);
        rr_model = id;
      end
    end
    if (start == 4'hF && keys == 16'h0) rr_model = start;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain_all();
    int guard;
    while (exp_q.size() > 0) begin
      guard = 0;
      while (!rd_valid && guard < 100) begin
        tick();
        guard++;
      end
      if (!rd_valid) begin
        check("drain_timeout", 32'(rd_valid), 32'd1);
        exp_q.delete();
      end else begin
        check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
      end
    end
  endtask

  task automatic idle_check(input string tag);
    repeat (20) tick();
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_fifo_cnt"}, 32'(fifo_cnt), 32'd0);
    check({tag, "_key_clear"}, 32'(key_clear), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_clear"}, 32'(key_clear), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_irq"}, 32'(irq), 32'd0);
    check({tag, "_fifo_cnt"}, 32'(fifo_cnt), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  initial begin
    logic [15:0] m;
    rst = 1'b1; key_reg = '0; rd_en = 1'b0; ovf_clr = 1'b0; rr_model = 4'hF;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single key 5: pulse timing and first-code latency.
    press_mask(16'h0020);
    push_round(16'h0020, DEPTH);
    for (int e = 1; e <= 12; e++) begin
      tick();
      check($sformatf("k5_key_clear_e%0d", e), 32'(key_clear), 32'((e >= 4 && e <= 7) ? 1 : 0));
      check($sformatf("k5_rd_valid_e%0d", e), 32'(rd_valid), 32'((e >= 11) ? 1 : 0));
    end
    drain_all();
    check("k5_irq_after_pop", 32'(irq), 32'd0);
    check("k5_cnt_after_pop", 32'(fifo_cnt), 32'd0);
    idle_check("k5");

    // Keys 9 and 3 in one round.
    press_mask(16'h0208);
    push_round(16'h0208, DEPTH);
    drain_all();
    idle_check("k93");

    // Ten keys, no pops: overflow keeps first DEPTH codes.
    press_mask(16'h03FF);
    push_round(16'h03FF, DEPTH);
    repeat (30) tick();
    check("ovf_fifo_cnt", 32'(fifo_cnt), 32'(DEPTH));
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_irq", 32'(irq), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);
    drain_all();
    idle_check("ovf");

    // Full FIFO while draining with rd_en held: push and pop each cycle.
    press_mask(16'h00FF);
    push_round(16'h00FF, DEPTH);
    repeat (30) tick();
    check("full_fill_cnt", 32'(fifo_cnt), 32'(DEPTH));
    press_mask(16'hFF00);
    push_round(16'hFF00, 2 * DEPTH);
    repeat (10) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      check("full_rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      rd_en = 1'b1;
      tick();
      check("full_cnt_hold", 32'(fifo_cnt), 32'(DEPTH));
      check("full_no_ovf", 32'(ovf), 32'd0);
    end
    rd_en = 1'b0;
    drain_all();
    idle_check("full");

    // Reset in the middle of CLEAR with key 12 latched.
    press_mask(16'h1000);
    repeat (5) tick();
    check("rst_in_clear", 32'(key_clear), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    rr_model = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    push_round(16'h1000, DEPTH);
    drain_all();
    idle_check("midrst_once");

    // Key 7 during the clear window is lost; a later key 7 is captured.
    press_mask(16'h0008);
    push_round(16'h0008, DEPTH);
    repeat (5) tick();
    check("k7_window", 32'(key_clear), 32'd1);
    press_mask(16'h0080);
    drain_all();
    idle_check("k7_lost");
    press_mask(16'h0080);
    push_round(16'h0080, DEPTH);
    drain_all();
    idle_check("k7_later");

    // Random rounds with continuous popping.
    for (int r = 0; r < 6; r++) begin
      m = 16'($urandom_range(1, 65535));
      press_mask(m);
      push_round(m, 2 * DEPTH);
      drain_all();
      idle_check($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
